// File: rtl/wash_cycle_sequencer.sv
// Wash program controller: steps the datapath through FILL, WASH, RINSE and SPIN with a per-phase
// down-counter, and handles door-open pause/resume and abort. All outputs come straight from flops.
module wash_cycle_sequencer #(
    parameter int unsigned FILL_CYC  = 8,
    parameter int unsigned WASH_CYC  = 16,
    parameter int unsigned RINSE_CYC = 8,
    parameter int unsigned SPIN_CYC  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       door_closed,
    input  logic       abort,
    output logic [2:0] dp_ctrl,
    output logic [7:0] dp_data,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       start_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_PAUSE = 3'd5,
        S_DONE  = 3'd6,
        S_BAD   = 3'd7
    } state_t;

    localparam logic [7:0] L_FILL  = 8'(FILL_CYC - 1);
    localparam logic [7:0] L_WASH  = 8'(WASH_CYC - 1);
    localparam logic [7:0] L_RINSE = 8'(RINSE_CYC - 1);
    localparam logic [7:0] L_SPIN  = 8'(SPIN_CYC - 1);

    function automatic logic f_active(input state_t s);
        f_active = (s == S_FILL) || (s == S_WASH) || (s == S_RINSE) || (s == S_SPIN);
    endfunction

    function automatic logic [2:0] f_ctrl(input state_t s);
        case (s)
            S_FILL:  f_ctrl = 3'b010;
            S_WASH:  f_ctrl = 3'b001;
            S_RINSE: f_ctrl = 3'b011;
            S_SPIN:  f_ctrl = 3'b001;
            default: f_ctrl = 3'b000;
        endcase
    endfunction

    function automatic state_t f_next_phase(input state_t s);
        case (s)
            S_FILL:  f_next_phase = S_WASH;
            S_WASH:  f_next_phase = S_RINSE;
            S_RINSE: f_next_phase = S_SPIN;
            default: f_next_phase = S_DONE;
        endcase
    endfunction

    function automatic logic [7:0] f_load(input state_t s);
        case (s)
            S_FILL:  f_load = L_FILL;
            S_WASH:  f_load = L_WASH;
            S_RINSE: f_load = L_RINSE;
            S_SPIN:  f_load = L_SPIN;
            default: f_load = 8'h00;
        endcase
    endfunction

    state_t     r_state;
    state_t     r_saved;
    logic [7:0] r_timer;
    logic [2:0] r_dp_ctrl;
    logic [7:0] r_dp_data;
    logic       r_busy;
    logic       r_done;
    logic       r_aborted;
    logic       r_start_err;

    state_t     w_state_nxt;
    state_t     w_saved_nxt;
    logic [7:0] w_timer_nxt;
    logic       w_aborted_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;

    // Next-state decision; abort outranks door-open, which outranks timer expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_saved_nxt   = r_saved;
        w_timer_nxt   = r_timer;
        w_aborted_nxt = r_aborted;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && door_closed) begin
                    w_state_nxt   = S_FILL;
                    w_timer_nxt   = L_FILL;
                    w_aborted_nxt = 1'b0;
                end else if (start) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_saved_nxt   = S_IDLE;
                    w_timer_nxt   = 8'h00;
                    w_aborted_nxt = 1'b1;
                end else if (!door_closed) begin
                    w_state_nxt = S_PAUSE;
                    w_saved_nxt = r_state;
                end else if (r_timer == 8'h00) begin
                    w_state_nxt = f_next_phase(r_state);
                    w_timer_nxt = f_load(f_next_phase(r_state));
                    w_done_nxt  = (r_state == S_SPIN);
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_saved_nxt   = S_IDLE;
                    w_timer_nxt   = 8'h00;
                    w_aborted_nxt = 1'b1;
                end else if (door_closed && start) begin
                    w_state_nxt = r_saved;
                end else begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = 8'h00;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_saved_nxt = S_IDLE;
                w_timer_nxt = 8'h00;
            end
        endcase
    end

    // State, timer and output registers; outputs are decoded from the next state so they align with phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_saved     <= S_IDLE;
            r_timer     <= 8'h00;
            r_dp_ctrl   <= 3'b000;
            r_dp_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_saved     <= w_saved_nxt;
            r_timer     <= w_timer_nxt;
            r_dp_ctrl   <= f_ctrl(w_state_nxt);
            r_dp_data   <= f_active(w_state_nxt) ? w_timer_nxt : 8'h00;
            r_busy      <= f_active(w_state_nxt) || (w_state_nxt == S_PAUSE);
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_start_err <= w_err_nxt;
        end
    end

    assign phase     = r_state;
    assign dp_ctrl   = r_dp_ctrl;
    assign dp_data   = r_dp_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign start_err = r_start_err;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Scoreboard bench for wash_cycle_sequencer: a program-level model predicts each cycle's outputs,
// a monitor pops and compares them after every rising edge.
module tb_wash_cycle_sequencer;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] ctrl;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic       ab;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       door_closed = 1'b1;
    logic       abort = 1'b0;
    logic [2:0] dp_ctrl;
    logic [7:0] dp_data;
    logic [2:0] phase;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       start_err;

    int n_vec = 0;
    int n_bad = 0;
    exp_t q[$];

    int   LEN[4]  = '{8, 16, 8, 12};
    logic [2:0] CODE[4] = '{3'b010, 3'b001, 3'b011, 3'b001};

    // mode: 0 idle, 1 running a stage, 2 paused in a stage, 3 finishing
    int m_mode = 0;
    int m_stage = 0;
    int m_rem = 0;
    bit m_ab = 0;
    bit m_done = 0;
    bit m_err = 0;

    wash_cycle_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .door_closed(door_closed), .abort(abort),
        .dp_ctrl(dp_ctrl), .dp_data(dp_data), .phase(phase), .busy(busy),
        .done(done), .aborted(aborted), .start_err(start_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out();
        exp_t e;
        e.ph   = (m_mode == 0) ? 3'd0 : (m_mode == 1) ? 3'(m_stage + 1) : (m_mode == 2) ? 3'd5 : 3'd6;
        e.ctrl = (m_mode == 1) ? CODE[m_stage] : 3'b000;
        e.data = (m_mode == 1) ? 8'(m_rem) : 8'h00;
        e.busy = (m_mode == 1) || (m_mode == 2);
        e.done = m_done;
        e.ab   = m_ab;
        e.err  = m_err;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_stage = 0; m_rem = 0; m_ab = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit s, input bit d, input bit a);
        m_done = 0;
        m_err  = 0;
        if (m_mode == 0) begin
            if (s && d) begin
                m_mode = 1; m_stage = 0; m_rem = LEN[0] - 1; m_ab = 0;
            end else if (s) begin
                m_err = 1;
            end
        end else if (m_mode == 3) begin
            m_mode = 0;
        end else if (a) begin
            m_mode = 0; m_rem = 0; m_ab = 1;
        end else if (m_mode == 1) begin
            if (!d) begin
                m_mode = 2;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end else if (m_stage == 3) begin
                m_mode = 3; m_rem = 0; m_done = 1;
            end else begin
                m_stage = m_stage + 1; m_rem = LEN[m_stage] - 1;
            end
        end else if (d && s) begin
            m_mode = 1;
        end
    endtask

    task automatic cyc(input bit s, input bit d, input bit a);
        @(negedge clk);
        start = s; door_closed = d; abort = a;
        model_step(s, d, a);
        q.push_back(model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; door_closed = 1'b1; abort = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({phase, dp_ctrl, dp_data, busy, done, aborted, start_err} !== 17'h0) begin
            n_bad++;
            $display("FAIL async_reset: got ph=%0d ctrl=%b data=%0d busy=%b done=%b ab=%b err=%b, want all 0",
                     phase, dp_ctrl, dp_data, busy, done, aborted, start_err);
        end
        model_reset();
        q.push_back(model_out());
        @(negedge clk);
        rst = 1'b1;
        model_step(1'b0, 1'b1, 1'b0);
        q.push_back(model_out());
    endtask

    task automatic run_until(input int stage, input int rem);
        int k;
        k = 0;
        while (!(m_mode == 1 && m_stage == stage && m_rem == rem) && k < 200) begin
            cyc(1'b0, 1'b1, 1'b0);
            k++;
        end
        if (k >= 200) begin
            n_vec++; n_bad++;
            $display("FAIL run_until: stage %0d rem %0d not reached in 200 cycles", stage, rem);
        end
    endtask

    task automatic run_idle();
        int k;
        k = 0;
        while (m_mode != 0 && k < 200) begin
            cyc(1'b0, 1'b1, 1'b0);
            k++;
        end
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: one expected entry per rising edge, compared shortly after the edge.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {phase, dp_ctrl, dp_data, busy, done, aborted, start_err};
                n_vec++;
                if (act !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard @%0t: got ph=%0d ctrl=%b data=%0d busy=%b done=%b ab=%b err=%b, want ph=%0d ctrl=%b data=%0d busy=%b done=%b ab=%b err=%b",
                             $time, act.ph, act.ctrl, act.data, act.busy, act.done, act.ab, act.err,
                             e.ph, e.ctrl, e.data, e.busy, e.done, e.ab, e.err);
                end
            end
        end
    end

    initial begin
        int n;
        do_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0);

        // nominal program: done must appear 44 edges after the start edge
        cyc(1'b1, 1'b1, 1'b0);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        n_vec++;
        if (n != 44) begin
            n_bad++;
            $display("FAIL done_latency: got %0d edges, want 44", n);
        end
        run_idle();

        // start rejected with door open
        cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);

        // door opened in WASH at 9, held 20 cycles, then resume
        cyc(1'b1, 1'b1, 1'b0);
        run_until(1, 9);
        repeat (20) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        run_idle();

        // abort together with door open in RINSE, then a fresh start
        cyc(1'b1, 1'b1, 1'b0);
        run_until(2, 4);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);

        // door opened on WASH timer 0, resume
        run_until(1, 0);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0);

        // async reset mid-SPIN, then stay idle until start
        run_until(3, 5);
        do_reset();
        repeat (5) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        run_idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0);
        end
        run_idle();

        @(posedge clk);
        #3;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d entries pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/wash_cycle_sequencer.md
# wash_cycle_sequencer

Controller that sequences the 8-bit wash datapath through a fixed FILL → WASH → RINSE → SPIN program. It drives the datapath's 3-bit operation code and 8-bit operand on every cycle and times each phase with a down-counter. It also handles door-open pause/resume and abort. It sits between the front-panel inputs and the datapath, and is the only source of the datapath's `ctrl`/`data_in`.

## Interface
- `FILL_CYC`, default 8: FILL phase length in cycles, legal range 1..255.
- `WASH_CYC`, default 16: WASH phase length in cycles, legal range 1..255.
- `RINSE_CYC`, default 8: RINSE phase length in cycles, legal range 1..255.
- `SPIN_CYC`, default 12: SPIN phase length in cycles, legal range 1..255.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `start`, input, 1: level-sampled start/resume request.
- `door_closed`, input, 1: 1 = door latched.
- `abort`, input, 1: cancel the program.
- `dp_ctrl`, output, 3: operation code to the datapath.
- `dp_data`, output, 8: operand to the datapath; equals the remaining-cycle count.
- `phase`, output, 3: current state encoding.
- `busy`, output, 1: 1 in FILL, WASH, RINSE, SPIN and PAUSE.
- `done`, output, 1: one-cycle pulse when the program completes.
- `aborted`, output, 1: sticky flag; cleared by the next accepted start.
- `start_err`, output, 1: one-cycle pulse when start is rejected because the door is open.

## Operation
- State encoding on `phase`: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, PAUSE=5, DONE=6. The value 7 is unreachable; if entered, the next cycle is IDLE.
- `dp_ctrl` per state: FILL=3'b010, WASH=3'b001, RINSE=3'b011, SPIN=3'b001. IDLE, PAUSE and DONE drive 3'b000.
- `dp_data` = timer value in FILL, WASH, RINSE and SPIN; 8'h00 otherwise.
- All outputs are registered and are not decoded combinationally from inputs.
- IDLE:
  - `start`=1 and `door_closed`=1 → FILL, timer←FILL_CYC-1, `aborted`←0.
  - `start`=1 and `door_closed`=0 → stay in IDLE, `start_err` pulses.
- Active phase (FILL, WASH, RINSE, SPIN):
  - Timer decrements by 1 per cycle.
  - When timer==0, the next state is the following phase, with the timer loaded to that phase's CYC-1.
  - SPIN at timer==0 goes to DONE.
  - Each phase therefore occupies exactly its CYC cycles.
- Timer is 8-bit unsigned and never wraps. The decrement is gated at 0.
- PAUSE:
  - Entered from an active phase when `door_closed`=0.
  - The interrupted phase is saved and the timer is frozen.
  - Resume requires `door_closed`=1 and `start`=1 in the same cycle. The machine returns to the saved phase with the timer unchanged, and decrementing restarts on the next cycle.
- DONE: lasts one cycle, `done`=1, then IDLE.
- Priority in active phases and PAUSE: `abort` > door open > timer expiry.
  - `abort`=1 → IDLE next cycle, `aborted`←1, timer←0.
  - `abort` in IDLE or DONE is ignored.
- Door opening on the same cycle the timer reaches 0 → PAUSE. On resume, the saved phase has timer 0 and advances after one cycle.
- `start` held high during active phases has no effect.

## Timing
- Reset values: `phase`=0, `dp_ctrl`=0, `dp_data`=0, `busy`=0, `done`=0, `aborted`=0, `start_err`=0, timer=0, saved phase=IDLE.
- Reset assertion mid-program forces these values immediately, without waiting for a clock edge.
- Start latency: `start` sampled at edge N → `phase`=FILL and `dp_ctrl`=3'b010 after edge N, with `dp_data`=FILL_CYC-1.
- Total program with no pauses, from the start edge to the `done` pulse: FILL_CYC+WASH_CYC+RINSE_CYC+SPIN_CYC cycles of active phases, then 1 cycle of DONE.
- PAUSE takes effect one cycle after `door_closed` falls. The timer value visible in PAUSE is the value held at the edge where the door was sampled open.
- `done` and `start_err` are single-cycle pulses.

## Test plan
- Default parameters, `start` pulse with door closed:
  - `phase` sequence is 1 ×8, 2 ×16, 3 ×8, 4 ×12, 6 ×1, then 0.
  - `dp_data` counts 7..0, 15..0, 7..0, 11..0.
  - `done` pulses exactly once, 44 cycles after FILL entry.
- Door opened in WASH when `dp_data`=9:
  - `phase`=5, `dp_ctrl`=0, and the timer holds 9 for 20 cycles.
  - Close door and pulse `start` → WASH resumes at 9 and completes. Total length increases by exactly the pause length + 1.
- `start` with `door_closed`=0 in IDLE → `start_err` is a 1-cycle pulse and `phase` stays 0.
- `abort` in RINSE simultaneous with door open → IDLE next cycle, `aborted`=1. The next valid start clears `aborted` and enters FILL.
- Reset asserted asynchronously mid-SPIN, between clock edges → all outputs are 0 before the next edge. After release, the machine stays in IDLE until `start`.
- Door opened on the WASH timer==0 cycle → PAUSE with saved WASH and timer 0. After resume: 1 WASH cycle, then RINSE with `dp_data`=7.
